// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline hazard and stall controller sitting beside the ID stage. Detects load-use hazards,
//   holds the front end while a multi-cycle execution unit is busy (with timeout/abort), and
//   flushes younger stages on a taken branch.
// Ports:
//   CLK, RESET         clock (rising edge), asynchronous active-high reset
//   exMemRead, exRd    EX instruction is a load / its destination register
//   idRs1, idRs2       ID instruction source registers
//   idUsesRs1/Rs2      ID instruction actually reads rs1 / rs2
//   mcStart, mcDone    ID op needs the multi-cycle unit / unit result-ready pulse
//   branchTaken        EX resolved a taken branch this cycle
//   stall              hold the PC register
//   ifIdStall          hold the IF/ID register
//   ifIdFlush          clear IF/ID to a NOP
//   idExBubble         load a NOP into ID/EX
//   mcGo, mcAbort      start / cancel pulses to the multi-cycle unit
//   mcError            sticky timeout flag, cleared only by RESET
//   stallCycles        saturating count of cycles with stall = 1
module hazard_stall_ctrl #(
   parameter int unsigned REGBITS   = 5,
   parameter int unsigned MCTIMEOUT = 64,
   parameter int unsigned CNTBITS   = 16
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               exMemRead,
   input  logic [REGBITS-1:0] exRd,
   input  logic [REGBITS-1:0] idRs1,
   input  logic [REGBITS-1:0] idRs2,
   input  logic               idUsesRs1,
   input  logic               idUsesRs2,
   input  logic               mcStart,
   input  logic               mcDone,
   input  logic               branchTaken,
   output logic               stall,
   output logic               ifIdStall,
   output logic               ifIdFlush,
   output logic               idExBubble,
   output logic               mcGo,
   output logic               mcAbort,
   output logic               mcError,
   output logic [CNTBITS-1:0] stallCycles
);

   localparam int unsigned WcntBits = $clog2(MCTIMEOUT + 1);
   localparam logic [WcntBits-1:0] WcntLast = WcntBits'(MCTIMEOUT - 1);

   typedef enum logic {StRun, StMcWait} state_e;

   state_e              state_q, state_d;
   logic [WcntBits-1:0] wcnt_q, wcnt_d;
   logic                err_q, err_set;
   logic [CNTBITS-1:0]  cnt_q;
   logic                load_use;

   // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
   assign load_use = exMemRead && (exRd != '0) &&
                     ((idUsesRs1 && (idRs1 == exRd)) || (idUsesRs2 && (idRs2 == exRd)));

   always_comb begin
      stall      = 1'b0;
      ifIdStall  = 1'b0;
      ifIdFlush  = 1'b0;
      idExBubble = 1'b0;
      mcGo       = 1'b0;
      mcAbort    = 1'b0;
      err_set    = 1'b0;
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      unique case (state_q)
         StRun: begin
            if (branchTaken) begin
               ifIdFlush  = 1'b1;
               idExBubble = 1'b1;
            end else if (load_use) begin
               stall      = 1'b1;
               ifIdStall  = 1'b1;
               idExBubble = 1'b1;
            end else if (mcStart) begin
               stall      = 1'b1;
               ifIdStall  = 1'b1;
               idExBubble = 1'b1;
               mcGo       = 1'b1;
               wcnt_d     = '0;
               state_d    = StMcWait;
            end
         end
         StMcWait: begin
            if (branchTaken) begin
               // An older branch kills the multi-cycle op sitting in ID.
               mcAbort    = 1'b1;
               ifIdFlush  = 1'b1;
               idExBubble = 1'b1;
               state_d    = StRun;
            end else if (mcDone) begin
               state_d = StRun;
            end else if (wcnt_q == WcntLast) begin
               mcAbort    = 1'b1;
               err_set    = 1'b1;
               ifIdFlush  = 1'b1;
               idExBubble = 1'b1;
               state_d    = StRun;
            end else begin
               stall      = 1'b1;
               ifIdStall  = 1'b1;
               idExBubble = 1'b1;
               wcnt_d     = wcnt_q + WcntBits'(1);
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= StRun;
         wcnt_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         if (err_set) begin
            err_q <= 1'b1;
         end
         if (stall && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNTBITS'(1);
         end
      end
   end

   assign mcError     = err_q;
   assign stallCycles = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized + directed bench for hazard_stall_ctrl. Two instances share the inputs:
// instance 0 has MCTIMEOUT=8/CNTBITS=16, instance 1 has MCTIMEOUT=32/CNTBITS=4 (saturation).
module tb_hazard_stall_ctrl;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       exMemRead = 1'b0;
   logic [4:0] exRd = '0;
   logic [4:0] idRs1 = '0;
   logic [4:0] idRs2 = '0;
   logic       idUsesRs1 = 1'b0;
   logic       idUsesRs2 = 1'b0;
   logic       mcStart = 1'b0;
   logic       mcDone = 1'b0;
   logic       branchTaken = 1'b0;

   logic [1:0] stall, ifIdStall, ifIdFlush, idExBubble, mcGo, mcAbort, mcError;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: whether an op is outstanding, the cycle its mcGo was issued,
   // the sticky error and the saturating stall count.
   int to_val[2]   = '{8, 32};
   int cnt_max[2]  = '{65535, 15};
   int m_busy[2];
   int m_go[2];
   int m_err[2];
   int m_cnt[2];
   int cyc = 0;

   always #5 CLK = ~CLK;

   hazard_stall_ctrl #(.REGBITS(5), .MCTIMEOUT(8), .CNTBITS(16)) u_dut_a (
      .CLK(CLK), .RESET(RESET), .exMemRead(exMemRead), .exRd(exRd), .idRs1(idRs1),
      .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2), .mcStart(mcStart),
      .mcDone(mcDone), .branchTaken(branchTaken), .stall(stall[0]), .ifIdStall(ifIdStall[0]),
      .ifIdFlush(ifIdFlush[0]), .idExBubble(idExBubble[0]), .mcGo(mcGo[0]),
      .mcAbort(mcAbort[0]), .mcError(mcError[0]), .stallCycles(cnt_a)
   );

   hazard_stall_ctrl #(.REGBITS(5), .MCTIMEOUT(32), .CNTBITS(4)) u_dut_b (
      .CLK(CLK), .RESET(RESET), .exMemRead(exMemRead), .exRd(exRd), .idRs1(idRs1),
      .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2), .mcStart(mcStart),
      .mcDone(mcDone), .branchTaken(branchTaken), .stall(stall[1]), .ifIdStall(ifIdStall[1]),
      .ifIdFlush(ifIdFlush[1]), .idExBubble(idExBubble[1]), .mcGo(mcGo[1]),
      .mcAbort(mcAbort[1]), .mcError(mcError[1]), .stallCycles(cnt_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [6:0] obs_ctl(input int k);
      return {stall[k], ifIdStall[k], ifIdFlush[k], idExBubble[k], mcGo[k], mcAbort[k],
              mcError[k]};
   endfunction

   function automatic int obs_cnt(input int k);
      return (k == 0) ? int'(cnt_a) : int'(cnt_b);
   endfunction

   task automatic clear_inputs();
      exMemRead = 1'b0; exRd = '0; idRs1 = '0; idRs2 = '0; idUsesRs1 = 1'b0;
      idUsesRs2 = 1'b0; mcStart = 1'b0; mcDone = 1'b0; branchTaken = 1'b0;
   endtask

   // Called at a falling edge with inputs already applied; checks, clocks, updates the model.
   task automatic step();
      bit lu;
      int s [2];
      int fl[2];
      int bb[2];
      int go[2];
      int ab[2];
      int e;
      #1;
      lu = exMemRead && (exRd != 0) &&
           ((idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd));
      for (int k = 0; k < 2; k++) begin
         s[k] = 0; fl[k] = 0; bb[k] = 0; go[k] = 0; ab[k] = 0;
         if (m_busy[k] == 0) begin
            if (branchTaken) begin
               fl[k] = 1; bb[k] = 1;
            end else if (lu) begin
               s[k] = 1; bb[k] = 1;
            end else if (mcStart) begin
               s[k] = 1; bb[k] = 1; go[k] = 1;
            end
         end else begin
            e = cyc - m_go[k];
            if (branchTaken) begin
               ab[k] = 1; fl[k] = 1; bb[k] = 1;
            end else if (mcDone) begin
               // op completes, nothing held
            end else if (e == to_val[k]) begin
               ab[k] = 1; fl[k] = 1; bb[k] = 1;
            end else begin
               s[k] = 1; bb[k] = 1;
            end
         end
         check($sformatf("ctl%0d@%0d", k, cyc), 32'(obs_ctl(k)),
               32'({s[k][0], s[k][0], fl[k][0], bb[k][0], go[k][0], ab[k][0],
                    m_err[k] != 0}));
         check($sformatf("cnt%0d@%0d", k, cyc), obs_cnt(k), m_cnt[k]);
      end
      @(posedge CLK);
      for (int k = 0; k < 2; k++) begin
         if (m_busy[k] != 0 && !branchTaken && !mcDone && (cyc - m_go[k]) == to_val[k])
            m_err[k] = 1;
         if (go[k] != 0) begin
            m_busy[k] = 1;
            m_go[k]   = cyc;
         end else if (m_busy[k] != 0 && (branchTaken || mcDone || ab[k] != 0)) begin
            m_busy[k] = 0;
         end
         m_cnt[k] = (m_cnt[k] + s[k] > cnt_max[k]) ? cnt_max[k] : m_cnt[k] + s[k];
      end
      cyc++;
      @(negedge CLK);
   endtask

   task automatic idle(input int n);
      clear_inputs();
      for (int i = 0; i < n; i++) step();
   endtask

   // Asynchronous reset applied between edges; outputs must drop at once.
   task automatic do_reset();
      clear_inputs();
      RESET = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_ctl%0d", k), 32'(obs_ctl(k)), 32'd0);
         check($sformatf("rst_cnt%0d", k), obs_cnt(k), 0);
         m_busy[k] = 0; m_go[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
      end
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 0; m_go[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
      end
      clear_inputs();
      @(negedge CLK);
      do_reset();
      idle(3);

      // Load-use: one stall cycle, then exRd = 0 gives none.
      exMemRead = 1'b1; exRd = 5'd5; idRs2 = 5'd5; idUsesRs2 = 1'b1;
      step();
      idle(1);
      check("lu_cnt", cnt_a, 1);
      exMemRead = 1'b1; exRd = 5'd0; idRs2 = 5'd0; idUsesRs2 = 1'b1;
      step();
      idle(1);
      check("lu_r0_cnt", cnt_a, 1);

      // Multi-cycle op with mcDone on the 4th cycle after mcGo.
      mcStart = 1'b1;
      step();
      idle(3);
      mcDone = 1'b1;
      step();
      idle(2);
      check("mc_cnt", cnt_a, 5);

      // Timeout on instance 0 (MCTIMEOUT=8): 8 stall cycles, abort in the 9th.
      do_reset();
      mcStart = 1'b1;
      step();
      idle(10);
      check("to_err", 32'(mcError[0]), 32'd1);
      check("to_cnt", cnt_a, 8);
      // Instance 1 is still waiting: branch + done together must abort it.
      branchTaken = 1'b1; mcDone = 1'b1;
      step();
      // Branch with load-use in RUN: flush wins, no stall.
      exMemRead = 1'b1; exRd = 5'd3; idRs1 = 5'd3; idUsesRs1 = 1'b1; branchTaken = 1'b1;
      step();
      idle(2);
      check("to_err_sticky", 32'(mcError[0]), 32'd1);

      // 20 stall cycles on instance 1 saturate its 4-bit counter.
      do_reset();
      mcStart = 1'b1;
      step();
      idle(19);
      mcDone = 1'b1;
      step();
      idle(1);
      check("sat_cnt", cnt_b, 15);

      // Reset in the middle of a wait.
      mcStart = 1'b1;
      step();
      idle(3);
      do_reset();
      idle(2);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            exMemRead   = ($urandom_range(0, 2) == 0);
            exRd        = 5'($urandom_range(0, 3));
            idRs1       = 5'($urandom_range(0, 3));
            idRs2       = 5'($urandom_range(0, 3));
            idUsesRs1   = 1'($urandom_range(0, 1));
            idUsesRs2   = 1'($urandom_range(0, 1));
            mcStart     = ($urandom_range(0, 3) == 0);
            mcDone      = ($urandom_range(0, 11) == 0);
            branchTaken = ($urandom_range(0, 15) == 0);
            step();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
